biker_squad_ctrl: RTL and testbench

//  Controller for NUM_BIKERS enemy bikers, replacing per-biker top instances.
//  Per biker: spawn/alive/hit/dead FSM, fixed-point motion with edge bounce and Y wrap,
//  and a shoot cooldown timer.

---
 rtl/biker_squad_ctrl.sv | 133 +++++++++++++
 tb/tb_biker_squad_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/biker_squad_ctrl.sv
// biker_squad_ctrl: per-biker spawn/motion/shoot FSMs with a shared lowest-index draw arbiter and squad-cleared event.
module biker_squad_ctrl #(
  parameter int NUM_BIKERS      = 4,
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int FRAC_BITS       = 6,
  parameter int X_BASE_SPEED    = 131,
  parameter int Y_BASE_SPEED    = 90,
  parameter int LEVEL_SPEED_MOD = 5,
  parameter int SPAWN_STAGGER   = 5,
  parameter int SHOOT_COOLDOWN  = 20,
  parameter int HIT_BLINK_TICKS = 10
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             startOfFrame,
  input  logic                             oneTensSec,
  input  logic                             startOfLevel,
  input  logic                             endLevel,
  input  logic [3:0]                       level,
  input  logic [7:0]                       random,
  input  logic [NUM_BIKERS-1:0]            collision,
  input  logic [NUM_BIKERS-1:0][10:0]      spawnX,
  input  logic [NUM_BIKERS-1:0][10:0]      spawnY,
  input  logic [10:0]                      pixelX,
  input  logic [10:0]                      pixelY,
  output logic [NUM_BIKERS-1:0][10:0]      bikerTLX,
  output logic [NUM_BIKERS-1:0][10:0]      bikerTLY,
  output logic [NUM_BIKERS-1:0]            alive,
  output logic [NUM_BIKERS-1:0]            movingRight,
  output logic [NUM_BIKERS-1:0]            shootRequest,
  output logic                             drawingRequest,
  output logic [2:0]                       drawIndex,
  output logic [10:0]                      offsetX,
  output logic [10:0]                      offsetY,
  output logic                             squadCleared
);
  localparam int PW = 11 + FRAC_BITS;
  localparam int XW = PW + 2;
  localparam int YW = PW + 1;
  localparam int CW = 8;
  localparam logic [XW-1:0] X_MAX = XW'((SCREEN_W - SPRITE_W) << FRAC_BITS);
  localparam logic [11:0]   Y_LIM = 12'(SCREEN_H);
  localparam logic [10:0]   SW11  = 11'(SPRITE_W);
  localparam logic [10:0]   SH11  = 11'(SPRITE_H);
  typedef enum logic [2:0] {IDLE, SPAWN_WAIT, ACTIVE, HIT, DEAD} state_t;
  logic [NUM_BIKERS-1:0] w_cand, w_dead;
  logic                  w_req, r_all_dead;
  logic [2:0]            w_idx;
  logic [10:0]           w_offx, w_offy;
  for (genvar g = 0; g < NUM_BIKERS; g++) begin : g_biker
    state_t          r_state, w_next;
    logic [PW-1:0]   r_x, r_y;
    logic [CW-1:0]   r_cnt, r_cd;
    logic [10:0]     r_speed;
    logic            r_right, r_shoot, w_vis;
    logic [XW-1:0]   w_nx;
    logic [YW-1:0]   w_ny;
    always_comb begin
      w_next = r_state;
      if (startOfLevel) w_next = SPAWN_WAIT;
      else if (endLevel && r_state != DEAD) w_next = IDLE;
      else if (r_state == SPAWN_WAIT && r_cnt == '0) w_next = ACTIVE;
      else if (r_state == ACTIVE && collision[g]) w_next = HIT;
      else if (r_state == HIT && r_cnt == '0) w_next = DEAD;
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
    // Underflow shows up as the top bit of the widened sum
    assign w_nx = r_right ? {2'b0, r_x} + XW'(r_speed) : {2'b0, r_x} - XW'(r_speed);
    assign w_ny = {1'b0, r_y} + YW'(Y_BASE_SPEED);
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        r_x <= '0; r_y <= '0; r_cnt <= '0; r_cd <= '0;
        r_speed <= '0; r_right <= 1'b0; r_shoot <= 1'b0;
      end else begin
        r_shoot <= 1'b0;
        if (startOfLevel) begin
          r_x     <= {spawnX[g], {FRAC_BITS{1'b0}}};
          r_y     <= {spawnY[g], {FRAC_BITS{1'b0}}};
          r_cnt   <= CW'(g * SPAWN_STAGGER);
          r_cd    <= CW'(SHOOT_COOLDOWN);
          r_right <= random[g % 8];
          r_speed <= 11'(X_BASE_SPEED) + 11'(level) * 11'(LEVEL_SPEED_MOD);
        end else if (!endLevel) begin
          if (r_state == ACTIVE && collision[g]) r_cnt <= CW'(HIT_BLINK_TICKS);
          else if ((r_state == SPAWN_WAIT || r_state == HIT) && oneTensSec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          if (r_state == ACTIVE) begin
            if (r_cd == '0 && random[g % 8]) begin
              r_shoot <= 1'b1;
              r_cd    <= CW'(SHOOT_COOLDOWN);
            end else if (oneTensSec && r_cd != '0) r_cd <= r_cd - 1'b1;
            if (startOfFrame && !collision[g]) begin
              r_x     <= w_nx[XW-1] ? '0 : (w_nx > X_MAX ? X_MAX[PW-1:0] : w_nx[PW-1:0]);
              r_right <= w_nx[XW-1] ? 1'b1 : (w_nx > X_MAX ? 1'b0 : r_right);
              r_y     <= w_ny[PW:FRAC_BITS] >= Y_LIM ? '0 : w_ny[PW-1:0];
            end
          end
        end
      end
    assign w_vis           = r_state == ACTIVE || (r_state == HIT && r_cnt[0]);
    assign bikerTLX[g]     = r_x[PW-1:FRAC_BITS];
    assign bikerTLY[g]     = r_y[PW-1:FRAC_BITS];
    assign alive[g]        = r_state == ACTIVE;
    assign movingRight[g]  = r_right;
    assign shootRequest[g] = r_shoot;
    assign w_dead[g]       = r_state == DEAD;
    assign w_cand[g]       = w_vis && pixelX >= bikerTLX[g] && (pixelX - bikerTLX[g]) < SW11 &&
                             pixelY >= bikerTLY[g] && (pixelY - bikerTLY[g]) < SH11;
  end
  // Scan from the top index down so the lowest candidate is written last
  always_comb begin
    w_req = 1'b0; w_idx = '0; w_offx = '0; w_offy = '0;
    for (int i = NUM_BIKERS - 1; i >= 0; i--)
      if (w_cand[i]) begin
        w_req  = 1'b1;
        w_idx  = 3'(i);
        w_offx = pixelX - bikerTLX[i];
        w_offy = pixelY - bikerTLY[i];
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      drawingRequest <= 1'b0; drawIndex <= '0; offsetX <= '0; offsetY <= '0; r_all_dead <= 1'b0;
    end else begin
      drawingRequest <= w_req; drawIndex <= w_idx; offsetX <= w_offx; offsetY <= w_offy;
      r_all_dead <= &w_dead;
    end
  assign squadCleared = &w_dead & ~r_all_dead;
endmodule

// File: tb/tb_biker_squad_ctrl.sv
// tb_biker_squad_ctrl: scoreboard bench for spawn timing, motion/bounce/wrap, draw arbitration, blink, shooting and squad-cleared.
module tb_biker_squad_ctrl;
  logic clk = 0, reset = 1, startOfFrame = 0, oneTensSec = 0, startOfLevel = 0, endLevel = 0;
  logic [3:0] level = 0;
  logic [7:0] random = 0;
  logic [3:0] collision = 0;
  logic [3:0][10:0] spawnX = '0, spawnY = '0;
  logic [10:0] pixelX = 0, pixelY = 0;
  logic [3:0][10:0] bikerTLX, bikerTLY;
  logic [3:0] alive, movingRight, shootRequest;
  logic drawingRequest, squadCleared;
  logic [2:0] drawIndex;
  logic [10:0] offsetX, offsetY;
  int n_checks = 0, n_errors = 0, n_clr = 0;
  typedef struct {string tag; int v;} exp_t;
  exp_t sb[$];

  biker_squad_ctrl dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .oneTensSec(oneTensSec),
    .startOfLevel(startOfLevel), .endLevel(endLevel), .level(level), .random(random),
    .collision(collision), .spawnX(spawnX), .spawnY(spawnY), .pixelX(pixelX), .pixelY(pixelY),
    .bikerTLX(bikerTLX), .bikerTLY(bikerTLY), .alive(alive), .movingRight(movingRight),
    .shootRequest(shootRequest), .drawingRequest(drawingRequest), .drawIndex(drawIndex),
    .offsetX(offsetX), .offsetY(offsetY), .squadCleared(squadCleared)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (squadCleared) n_clr++;

  task automatic chk(string tag, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic push(string tag, int v);
    sb.push_back('{tag, v});
  endtask
  task automatic pop(int act);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk(e.tag, act, e.v);
  endtask
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic tick();
    oneTensSec = 1; step(); oneTensSec = 0; step();
  endtask
  task automatic frame();
    startOfFrame = 1; step(); startOfFrame = 0;
  endtask
  task automatic start(logic [3:0] lv, logic [7:0] rnd);
    level = lv; random = rnd; startOfLevel = 1; step(); startOfLevel = 0;
  endtask
  task automatic draw(string tag, int px, int py, int req, int idx, int ox, int oy);
    pixelX = 11'(px); pixelY = 11'(py);
    push({tag, "_req"}, req); push({tag, "_idx"}, idx); push({tag, "_offx"}, ox); push({tag, "_offy"}, oy);
    step();
    pop(drawingRequest); pop(drawIndex); pop(offsetX); pop(offsetY);
  endtask
  task automatic zeros(string tag);
    push({tag, "_alive"}, 0); push({tag, "_tlx0"}, 0); push({tag, "_tly0"}, 0); push({tag, "_right"}, 0);
    push({tag, "_shoot"}, 0); push({tag, "_draw"}, 0); push({tag, "_clr"}, 0);
    pop(alive); pop(bikerTLX[0]); pop(bikerTLY[0]); pop(movingRight);
    pop(shootRequest); pop(drawingRequest); pop(squadCleared);
  endtask

  initial begin
    int x, y, r, base;
    step(3);
    zeros("por");
    reset = 0;
    step();
    spawnX = {11'd400, 11'd300, 11'd100, 11'd100};
    spawnY = {11'd300, 11'd200, 11'd100, 11'd100};
    // level 2 spawn timing and straight-line motion
    start(2, 8'h01);
    push("alive_load", 0); pop(alive);
    step();
    push("alive_b0", 1); pop(alive);
    repeat (64) frame();
    push("tlx_64f", 241); pop(bikerTLX[0]);
    push("tly_64f", 190); pop(bikerTLY[0]);
    push("right_64f", 1); pop(movingRight[0]);
    push("tlx_b1_waiting", 100); pop(bikerTLX[1]);
    repeat (14) tick();
    push("alive_14t", 4'b0111); pop(alive);
    tick();
    push("alive_15t", 4'b1111); pop(alive);
    reset = 1;
    step(3);
    zeros("mid_reset");
    reset = 0;
    step();
    push("alive_after_reset", 0); pop(alive);
    // right-edge clamp/bounce and Y wrap on biker 0
    spawnX[0] = 11'd600; spawnY[0] = 11'd470;
    start(0, 8'h01);
    step();
    x = 600 * 64; y = 470 * 64; r = 1;
    for (int f = 0; f < 9; f++) begin
      x = r ? x + 131 : x - 131;
      if (x > 608 * 64) begin x = 608 * 64; r = 0; end
      if (x < 0) begin x = 0; r = 1; end
      y += 90;
      if (y >= 480 * 64) y = 0;
      push("edge_tlx", x / 64); push("edge_tly", y / 64); push("edge_right", r);
      frame();
      pop(bikerTLX[0]); pop(bikerTLY[0]); pop(movingRight[0]);
    end
    // draw arbitration, hit blink and shoot cadence
    spawnX = {11'd400, 11'd300, 11'd100, 11'd100};
    spawnY = {11'd300, 11'd200, 11'd100, 11'd100};
    start(0, 8'hFF);
    step();
    push("c_alive_b0", 1); pop(alive);
    repeat (15) tick();
    push("c_alive_all", 4'hF); pop(alive);
    draw("ovl", 110, 110, 1, 0, 10, 10);
    draw("corner", 131, 131, 1, 0, 31, 31);
    draw("past_edge", 132, 110, 0, 0, 0, 0);
    draw("b2", 305, 210, 1, 2, 5, 10);
    draw("none", 50, 50, 0, 0, 0, 0);
    pixelX = 11'd110; pixelY = 11'd110;
    collision = 4'b0001; startOfFrame = 1;
    step();
    collision = 0; startOfFrame = 0;
    push("hit_tlx0", 100); pop(bikerTLX[0]);
    push("hit_tly0", 100); pop(bikerTLY[0]);
    push("hit_alive", 4'b1110); pop(alive);
    push("hit_tlx1", 102); pop(bikerTLX[1]);
    draw("blink_off", 110, 110, 1, 1, 8, 9);
    tick();
    push("blink_on_idx", 0); pop(drawIndex);
    push("blink_on_offx", 10); pop(offsetX);
    tick();
    push("blink_off2_idx", 1); pop(drawIndex);
    for (int k = 18; k <= 60; k++) begin
      push($sformatf("shoot_t%0d", k), {k == 35 || k == 55, k == 30 || k == 50, k == 25 || k == 45, 1'b0});
      tick();
      pop(shootRequest);
    end
    push("no_clr_yet", 0); pop(n_clr);
    // simultaneous final deaths
    start(0, 8'h00);
    step();
    repeat (15) tick();
    push("d_alive_all", 4'hF); pop(alive);
    base = n_clr;
    collision = 4'hF;
    step();
    collision = 0;
    push("d_alive_hit", 0); pop(alive);
    repeat (9) tick();
    push("clr_9t", 0); pop(n_clr - base);
    tick();
    step(3);
    push("clr_10t", 1); pop(n_clr - base);
    // endLevel freezes to IDLE; startOfLevel wins over endLevel
    start(0, 8'h00);
    step();
    endLevel = 1;
    step();
    endLevel = 0;
    push("end_alive", 0); pop(alive);
    repeat (20) tick();
    push("end_idle", 0); pop(alive);
    startOfLevel = 1; endLevel = 1;
    step();
    startOfLevel = 0; endLevel = 0;
    step();
    push("start_wins", 1); pop(alive[0]);
    push("clr_total", 1); pop(n_clr - base);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
